// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIB_W = 4;

  // A single-nibble adder still needs a 1-bit counter register.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/cla4_stage.sv
// rtl/cla4_stage.sv - combinational 4-bit carry-lookahead adder slice
module cla4_stage (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:1] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is flattened to generate/propagate terms so no carry ripples.
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c[3:1], cin};
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that runs one 4-bit CLA slice per cycle, LSB nibble first
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus,
  output logic                 busy
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int CW  = cnt_width(NIB);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic [3:0]       slice_s;
  logic             slice_cout;
  logic             accept;
  logic             last;

  cla4_stage u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt == CW'(NIB - 1));

  // New nibble enters at the top; after NIB steps the LSB nibble has reached bit 0.
  always_comb begin
    sum_shift = sum_r >> NIB_W;
    sum_shift[WIDTH-1 -: NIB_W] = slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = rst_n;
        if (accept) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && accept) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> NIB_W;
        b_sh  <= b_sh >> NIB_W;
        sum_r <= sum_shift;
        carry <= slice_cout;
        cnt   <= cnt + CW'(1);
        if (last) cout_r <= slice_cout;
      end
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder (WIDTH 16 and 4)
module tb_nibble_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy16;
  logic busy4;
  int   ncmp  = 0;
  int   nfail = 0;
  int   cyc;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16),
    .busy  (busy16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .busy  (busy4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the accept edge.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    chk("in_ready16 before accept", 32'(bus16.in_ready), 32'd1);
    bus16.in_valid = 1'b1;
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait16(output int n);
    n = 0;
    while (!bus16.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish16(input string tag);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid after ack"}, 32'(bus16.out_valid), 32'd0);
    chk({tag, " in_ready after ack"}, 32'(bus16.in_ready), 32'd1);
    bus16.out_ready = 1'b0;
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [15:0] exp_sum, input logic exp_cout);
    int n;
    start16(a, b, cin);
    wait16(n);
    chk({tag, " latency"}, 32'(n), 32'd4);
    chk({tag, " sum"}, 32'(bus16.sum), 32'(exp_sum));
    chk({tag, " cout"}, 32'(bus16.cout), 32'(exp_cout));
    finish16(tag);
  endtask

  initial begin
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;

    #1;
    chk("reset out_valid16", 32'(bus16.out_valid), 32'd0);
    chk("reset in_ready16", 32'(bus16.in_ready), 32'd0);
    chk("reset sum16", 32'(bus16.sum), 32'd0);
    chk("reset cout16", 32'(bus16.cout), 32'd0);
    chk("reset busy16", 32'(busy16), 32'd0);
    chk("reset in_ready4", 32'(bus4.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release in_ready16", 32'(bus16.in_ready), 32'd1);
    chk("release in_ready4", 32'(bus4.in_ready), 32'd1);

    op16("1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    op16("ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    op16("ffff+0000+c", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Backpressure: result held for 5 cycles while a stray in_valid pulse arrives.
    start16(16'h1234, 16'h4321, 1'b0);
    wait16(cyc);
    chk("bp latency", 32'(cyc), 32'd4);
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid held", 32'(bus16.out_valid), 32'd1);
      chk("bp sum held", 32'(bus16.sum), 32'h5555);
      chk("bp cout held", 32'(bus16.cout), 32'd0);
      chk("bp in_ready low", 32'(bus16.in_ready), 32'd0);
      if (k == 1) begin
        bus16.in_valid = 1'b1;
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'hFFFF;
      end
      if (k == 3) bus16.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp sum after stray pulse", 32'(bus16.sum), 32'h5555);
    finish16("bp");
    @(negedge clk);
    chk("bp stray pulse not accepted", 32'(busy16), 32'd0);

    // Operands change right after the accept edge.
    start16(16'h0001, 16'h0002, 1'b0);
    bus16.a   = 16'hAAAA;
    bus16.b   = 16'hAAAA;
    bus16.cin = 1'b1;
    wait16(cyc);
    chk("late change latency", 32'(cyc), 32'd4);
    chk("late change sum", 32'(bus16.sum), 32'h0003);
    chk("late change cout", 32'(bus16.cout), 32'd0);
    bus16.cin = 1'b0;
    finish16("late change");

    // Reset asserted after two RUN cycles.
    start16(16'h1234, 16'h4321, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun reset out_valid", 32'(bus16.out_valid), 32'd0);
    chk("midrun reset sum", 32'(bus16.sum), 32'd0);
    chk("midrun reset busy", 32'(busy16), 32'd0);
    chk("midrun reset in_ready", 32'(bus16.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrun release in_ready", 32'(bus16.in_ready), 32'd1);
    op16("00f0+0f10", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0);

    // Single-nibble instance.
    @(negedge clk);
    chk("w4 in_ready before accept", 32'(bus4.in_ready), 32'd1);
    bus4.in_valid = 1'b1;
    bus4.a        = 4'h9;
    bus4.b        = 4'h8;
    bus4.cin      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    cyc = 0;
    while (!bus4.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("w4 latency", 32'(cyc), 32'd1);
    chk("w4 sum", 32'(bus4.sum), 32'h2);
    chk("w4 cout", 32'(bus4.cout), 32'd1);
    bus4.out_ready = 1'b1;
    @(negedge clk);
    chk("w4 out_valid after ack", 32'(bus4.out_valid), 32'd0);
    chk("w4 in_ready after ack", 32'(bus4.in_ready), 32'd1);
    bus4.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
